// File: rtl/hack_cpu_ctrl.sv
// HACK core control/register stage: multi-cycle fetch, decode, optional M read,
// execute through an external combinational ALU, and optional M write-back.
module hack_cpu_ctrl (
  input  logic        clk,
  input  logic        reset,
  output logic        instr_req,
  output logic [14:0] instr_addr,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        data_rd,
  output logic        data_wr,
  output logic [14:0] data_addr,
  output logic [15:0] data_wdata,
  input  logic [15:0] data_rdata,
  input  logic        data_ack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_ctl,
  input  logic [15:0] alu_out,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg,
  output logic        instr_done
);

  typedef enum logic [2:0] {FETCH, DECODE, MREAD, EXEC, MWRITE} state_t;

  state_t      state_reg;
  logic [14:0] pc_reg;
  logic [15:0] ir_reg;
  logic [15:0] mdr_reg;
  logic        zr;
  logic        ng;
  logic        taken;

  assign instr_addr = pc_reg;

  // ALU operands come straight from architectural registers, so they are
  // stable for the whole EXEC cycle and read as zero while in reset.
  assign alu_x   = d_reg;
  assign alu_y   = ir_reg[12] ? mdr_reg : a_reg;
  assign alu_ctl = {ir_reg[11], ir_reg[9], ir_reg[10], ir_reg[8], ir_reg[7], ir_reg[6]};

  assign zr    = (alu_out == 16'h0000);
  assign ng    = alu_out[15];
  assign taken = (ir_reg[2] & ng) | (ir_reg[1] & zr) | (ir_reg[0] & ~zr & ~ng);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= FETCH;
      pc_reg     <= 15'h0000;
      ir_reg     <= 16'h0000;
      mdr_reg    <= 16'h0000;
      a_reg      <= 16'h0000;
      d_reg      <= 16'h0000;
      instr_req  <= 1'b0;
      data_rd    <= 1'b0;
      data_wr    <= 1'b0;
      data_addr  <= 15'h0000;
      data_wdata <= 16'h0000;
      instr_done <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      case (state_reg)
        FETCH: begin
          // instr_req is only low here on the first cycle out of reset
          if (!instr_req) begin
            instr_req <= 1'b1;
          end else if (instr_valid) begin
            ir_reg    <= instr;
            instr_req <= 1'b0;
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          if (!ir_reg[15]) begin
            a_reg      <= ir_reg;
            pc_reg     <= pc_reg + 15'd1;
            instr_done <= 1'b1;
            instr_req  <= 1'b1;
            state_reg  <= FETCH;
          end else if (ir_reg[12]) begin
            data_rd   <= 1'b1;
            data_addr <= a_reg[14:0];
            state_reg <= MREAD;
          end else begin
            state_reg <= EXEC;
          end
        end
        MREAD: begin
          if (data_ack) begin
            mdr_reg   <= data_rdata;
            data_rd   <= 1'b0;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          // write address, jump target and dest updates all see the old A
          data_addr  <= a_reg[14:0];
          data_wdata <= alu_out;
          if (ir_reg[5]) a_reg <= alu_out;
          if (ir_reg[4]) d_reg <= alu_out;
          pc_reg <= taken ? a_reg[14:0] : pc_reg + 15'd1;
          if (ir_reg[3]) begin
            data_wr   <= 1'b1;
            state_reg <= MWRITE;
          end else begin
            instr_done <= 1'b1;
            instr_req  <= 1'b1;
            state_reg  <= FETCH;
          end
        end
        MWRITE: begin
          if (data_ack) begin
            data_wr    <= 1'b0;
            instr_done <= 1'b1;
            instr_req  <= 1'b1;
            state_reg  <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: an ISA-level HACK model predicts every instruction's
// effect, latency and memory traffic; directed cases then randomized programs.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req;
  logic [14:0] instr_addr;
  logic        instr_valid;
  logic [15:0] instr;
  logic        data_rd;
  logic        data_wr;
  logic [14:0] data_addr;
  logic [15:0] data_wdata;
  logic [15:0] data_rdata;
  logic        data_ack;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctl;
  logic [15:0] alu_out;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic        instr_done;

  always #5 clk = ~clk;

  hack_cpu_ctrl dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_valid(instr_valid), .instr(instr),
    .data_rd(data_rd), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ack(data_ack),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl), .alu_out(alu_out),
    .a_reg(a_reg), .d_reg(d_reg), .instr_done(instr_done)
  );

  function automatic logic [15:0] alu_fn(input logic zx, input logic nx, input logic zy,
                                         input logic ny, input logic f, input logic no,
                                         input logic [15:0] x, input logic [15:0] y);
    logic [15:0] xx, yy, r;
    xx = zx ? 16'h0000 : x;
    xx = nx ? ~xx : xx;
    yy = zy ? 16'h0000 : y;
    yy = ny ? ~yy : yy;
    r  = f ? xx + yy : xx & yy;
    return no ? ~r : r;
  endfunction

  // External ALU, wired in its own port order {zx,zy,nx,ny,f,no}
  always_comb alu_out = alu_fn(alu_ctl[5], alu_ctl[3], alu_ctl[4], alu_ctl[2],
                               alu_ctl[1], alu_ctl[0], alu_x, alu_y);

  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  logic [15:0] cap_x, cap_y;
  logic [5:0]  cap_ctl;
  logic [15:0] last_wdata;
  logic [14:0] last_waddr, last_raddr;
  int          abort_wr = -1;
  bit          aborted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from the model PC; fw/rw/ww are wait cycles before
  // instr_valid / read ack / write ack. Entered and left on a negedge.
  task automatic run_instr(input int fw, input int rw, input int ww);
    logic [15:0] ins, old_a, old_d, mval, res;
    logic [14:0] old_pc;
    logic        exp_rd, exp_wr, taken;
    int          lat, exec_k, k, rcyc, wcyc;
    bit          done;
    ins    = imem[m_pc];
    old_a  = m_a;
    old_d  = m_d;
    old_pc = m_pc;
    exp_rd = ins[15] & ins[12];
    exp_wr = ins[15] & ins[3];
    mval   = dmem[old_a[14:0]];
    res    = 16'h0000;
    if (!ins[15]) begin
      m_a  = ins;
      m_pc = old_pc + 15'd1;
      lat  = fw + 2;
    end else begin
      res   = alu_fn(ins[11], ins[10], ins[9], ins[8], ins[7], ins[6], old_d,
                     ins[12] ? mval : old_a);
      taken = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'h0000) ||
              (ins[0] && $signed(res) > 0);
      if (ins[5]) m_a = res;
      if (ins[4]) m_d = res;
      m_pc = taken ? old_a[14:0] : old_pc + 15'd1;
      lat  = fw + 3 + (exp_rd ? 1 + rw : 0) + (exp_wr ? 1 + ww : 0);
    end
    exec_k = fw + 2 + (exp_rd ? 1 + rw : 0);

    k = 0;
    while (!instr_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("fetch_start", instr_req, 1'b1);

    k = 0; rcyc = 0; wcyc = 0; done = 0; aborted = 0;
    while (!done && !aborted && k < 60) begin
      instr_valid = 1'b0;
      data_ack    = 1'b0;
      if (k > 0 && instr_done) begin
        done = 1;
      end else begin
        if (k <= fw) begin
          check("fetch_req", instr_req, 1'b1);
          check("fetch_addr", instr_addr, old_pc);
          if (k == fw) begin
            instr_valid = 1'b1;
            instr       = ins;
          end
        end else begin
          check("fetch_drop", instr_req, 1'b0);
        end
        if (k == exec_k) begin
          cap_x   = alu_x;
          cap_y   = alu_y;
          cap_ctl = alu_ctl;
        end
        if (data_rd) begin
          rcyc++;
          check("rd_addr", data_addr, old_a[14:0]);
          if (rcyc == rw + 1) begin
            data_ack   = 1'b1;
            data_rdata = dmem[data_addr];
            last_raddr = data_addr;
          end
        end
        if (data_wr) begin
          wcyc++;
          check("wr_addr", data_addr, old_a[14:0]);
          check("wr_data", data_wdata, res);
          if (abort_wr >= 0 && wcyc == abort_wr + 1) begin
            reset   = 1'b1;
            aborted = 1;
          end else if (wcyc == ww + 1) begin
            data_ack   = 1'b1;
            last_wdata = data_wdata;
            last_waddr = data_addr;
          end
        end
        @(negedge clk);
        k++;
      end
    end
    if (aborted) return;

    check("retire", done, 1'b1);
    check("latency", k, lat);
    check("rd_cycles", rcyc, exp_rd ? rw + 1 : 0);
    check("wr_cycles", wcyc, exp_wr ? ww + 1 : 0);
    check("a_reg", a_reg, m_a);
    check("d_reg", d_reg, m_d);
    if (ins[15]) begin
      check("alu_x", cap_x, old_d);
      check("alu_y", cap_y, ins[12] ? mval : old_a);
    end
    if (exp_wr) dmem[old_a[14:0]] = res;
    $display("[TB] pc=%h ins=%h A=%h D=%h next_pc=%h cycles=%0d", old_pc, ins, m_a, m_d, m_pc, k);
  endtask

  initial begin
    instr_valid = 1'b0;
    instr       = 16'h0000;
    data_ack    = 1'b0;
    data_rdata  = 16'h0000;
    for (int i = 0; i < 32768; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 16'($urandom);
    end
    repeat (3) @(negedge clk);
    check("rst_instr_req", instr_req, 1'b0);
    check("rst_data_rd", data_rd, 1'b0);
    check("rst_data_wr", data_wr, 1'b0);
    check("rst_done", instr_done, 1'b0);
    check("rst_pc", instr_addr, 15'h0);
    check("rst_data_addr", data_addr, 15'h0);
    check("rst_wdata", data_wdata, 16'h0);
    check("rst_alu", {alu_x, alu_y, 10'(alu_ctl)}, 42'h0);
    check("rst_a", a_reg, 16'h0);
    check("rst_d", d_reg, 16'h0);

    imem[0]  = 16'h0005; imem[1]  = 16'hEC10; imem[2]  = 16'h0064; imem[3]  = 16'hE7C8;
    imem[4]  = 16'h0010; imem[5]  = 16'hEA87;
    imem[16] = 16'hEA90; imem[17] = 16'h0020; imem[18] = 16'hE302;
    imem[32] = 16'hEFD0; imem[33] = 16'h0030; imem[34] = 16'hE302;
    imem[35] = 16'h0007; imem[36] = 16'hFC10; imem[37] = 16'h7FFF; imem[38] = 16'hEA87;
    imem[32767] = 16'h0003;
    dmem[7] = 16'h1234;
    m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
    reset = 1'b0;

    run_instr(0, 0, 0);
    check("a_first", a_reg, 16'h0005);
    run_instr(0, 0, 0);
    check("ec10_ctl", cap_ctl, 6'b101000);
    check("ec10_y", cap_y, 16'h0005);
    check("ec10_d", d_reg, 16'h0005);
    run_instr(1, 0, 0);
    run_instr(0, 0, 3);
    check("e7c8_waddr", last_waddr, 15'd100);
    check("e7c8_wdata", last_wdata, 16'h0006);
    run_instr(0, 0, 0);
    run_instr(2, 0, 0);
    check("jmp_target", instr_addr, 15'h0010);
    run_instr(0, 0, 0);
    run_instr(0, 0, 0);
    run_instr(0, 0, 0);
    check("jeq_taken", instr_addr, 15'h0020);
    run_instr(0, 0, 0);
    run_instr(0, 0, 0);
    run_instr(1, 0, 0);
    check("jeq_not_taken", instr_addr, 15'd35);
    run_instr(0, 0, 0);
    run_instr(0, 1, 0);
    check("fc10_raddr", last_raddr, 15'd7);
    check("fc10_y", cap_y, 16'h1234);
    check("fc10_d", d_reg, 16'h1234);
    run_instr(0, 0, 0);
    run_instr(0, 0, 0);
    check("jmp_top", instr_addr, 15'h7FFF);
    run_instr(0, 0, 0);
    check("pc_wrap", instr_addr, 15'h0000);

    // Re-run A=5, D=A, A=100 and abort M=D+1 while its write is waiting
    run_instr(0, 0, 0);
    run_instr(0, 0, 0);
    run_instr(0, 0, 0);
    abort_wr = 1;
    run_instr(0, 0, 5);
    abort_wr = -1;
    check("abort_reached", aborted, 1'b1);
    check("abort_wr", data_wr, 1'b0);
    check("abort_req", instr_req, 1'b0);
    check("abort_done", instr_done, 1'b0);
    check("abort_pc", instr_addr, 15'h0);
    check("abort_a", a_reg, 16'h0);
    check("abort_d", d_reg, 16'h0);
    reset    = 1'b0;
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("stray_wr", data_wr, 1'b0);
    check("stray_rd", data_rd, 1'b0);
    check("stray_done", instr_done, 1'b0);
    check("stray_a", a_reg, 16'h0);
    check("stray_d", d_reg, 16'h0);
    m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
    run_instr(0, 0, 0);

    // Random programs over the full instruction space (bits 14:13 of C-instrs random too)
    for (int i = 0; i < 32768; i++) begin
      if ($urandom_range(1, 0) == 1) imem[i] = {1'b0, 15'($urandom)};
      else                           imem[i] = 16'($urandom) | 16'h8000;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
    for (int n = 0; n < 300; n++)
      run_instr($urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(2, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
